// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, read-only instruction store, 2-entry output buffer, flush/redirect.
// Optional perf counters (stall_cnt, fetch_cnt) are built when IFU_PERF_CNT_EN is defined.
module inst_fetch_unit #(
    parameter int unsigned INST_LEN = 17,
    parameter int unsigned INST_CAP = 5,
    parameter int unsigned PC_LEN   = 3,
    parameter int unsigned CNT_LEN  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic [PC_LEN-1:0]   flush_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INST_LEN-1:0] out_inst,
    output logic [PC_LEN-1:0]   out_pc,
    output logic                done
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [CNT_LEN-1:0]  stall_cnt,
    output logic [CNT_LEN-1:0]  fetch_cnt
`endif
);

    localparam logic [PC_LEN-1:0] CAP_PC = PC_LEN'(INST_CAP);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Loaded from outside the block (testbench hierarchical write); never written here.
    logic [INST_LEN-1:0] inst_mem [0:INST_CAP-1];

    state_t              state, state_n;
    logic [PC_LEN-1:0]   pc;
    logic [1:0]          count, count_n;
    logic [INST_LEN-1:0] tail_inst;
    logic [PC_LEN-1:0]   tail_pc;
    logic [INST_LEN-1:0] fetch_word;
    logic                push, pop;

    assign fetch_word = (pc < CAP_PC) ? inst_mem[pc] : '0;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_FETCH;
        else       state <= state_n;
    end

    // Next state and push/pop decisions; flush overrides everything
    always_comb begin
        state_n = state;
        push    = 1'b0;
        pop     = 1'b0;
        count_n = count;
        case (state)
            S_FETCH: begin
                if (pc >= CAP_PC) state_n = S_DRAIN;
                else              push    = (count != 2'd2);
            end
            S_DRAIN: begin
                if (count == 2'd0) state_n = S_DONE;
            end
            S_DONE:  state_n = S_DONE;
            default: state_n = S_FETCH;
        endcase
        pop = out_valid && out_ready;
        if (flush) begin
            state_n = S_FETCH;
            push    = 1'b0;
            pop     = 1'b0;
            count_n = 2'd0;
        end else begin
            count_n = count + 2'(push) - 2'(pop);
        end
    end

    // PC, buffer storage and registered outputs; head entry drives out_inst/out_pc directly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc        <= '0;
            count     <= 2'd0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
            tail_inst <= '0;
            tail_pc   <= '0;
            done      <= 1'b0;
        end else begin
            count     <= count_n;
            out_valid <= (count_n != 2'd0);
            done      <= (state_n == S_DONE);
            if (flush) begin
                pc        <= flush_pc;
                out_inst  <= '0;
                out_pc    <= '0;
                tail_inst <= '0;
                tail_pc   <= '0;
            end else begin
                pc <= pc + PC_LEN'(push);
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            out_inst <= fetch_word;
                            out_pc   <= pc;
                        end else begin
                            tail_inst <= fetch_word;
                            tail_pc   <= pc;
                        end
                    end
                    2'b01: begin
                        // tail is kept zero when unoccupied, so shifting it in empties the head too
                        out_inst  <= tail_inst;
                        out_pc    <= tail_pc;
                        tail_inst <= '0;
                        tail_pc   <= '0;
                    end
                    2'b11: begin
                        out_inst <= fetch_word;
                        out_pc   <= pc;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Saturating perf counters; only reset clears them
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
            fetch_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_LEN'(1);
            if (push && (fetch_cnt != '1))
                fetch_cnt <= fetch_cnt + CNT_LEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed table, corner sequences, randomized run vs queue model.
module tb_inst_fetch_unit;

    localparam int unsigned INST_LEN = 17;
    localparam int unsigned INST_CAP = 5;
    localparam int unsigned PC_LEN   = 3;
    localparam int unsigned CNT_LEN  = 16;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                flush = 1'b0;
    logic [PC_LEN-1:0]   flush_pc = '0;
    logic                out_ready = 1'b0;
    logic                out_valid;
    logic [INST_LEN-1:0] out_inst;
    logic [PC_LEN-1:0]   out_pc;
    logic                done;
`ifdef IFU_PERF_CNT_EN
    logic [CNT_LEN-1:0]  stall_cnt;
    logic [CNT_LEN-1:0]  fetch_cnt;
`endif

    inst_fetch_unit #(
        .INST_LEN(INST_LEN), .INST_CAP(INST_CAP), .PC_LEN(PC_LEN), .CNT_LEN(CNT_LEN)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .flush_pc(flush_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .done(done)
`ifdef IFU_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .fetch_cnt(fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program store, FIFO of {inst,pc}, PC and program phase
    logic [INST_LEN-1:0] mmem [INST_CAP];
    logic [19:0]         mq [$];
    logic [19:0]         got [$];
    int                  mpc;
    int                  mphase;   // 0 fetching, 1 draining, 2 done
    int unsigned         m_stall, m_fetch;

    function automatic void model_reset();
        mq.delete();
        mpc = 0; mphase = 0; m_stall = 0; m_fetch = 0;
    endfunction

    function automatic void model_edge(input logic f, input logic [2:0] fp, input logic r);
        bit v, psh, pp;
        v = (mq.size() != 0);
        if (v && !r && m_stall != 32'hFFFF) m_stall++;
        if (f) begin
            mq.delete();
            mpc = int'(fp);
            mphase = 0;
        end else begin
            psh = (mphase == 0) && (mpc < INST_CAP) && (mq.size() < 2);
            pp  = v && r;
            if (mphase == 0 && mpc >= INST_CAP) mphase = 1;
            else if (mphase == 1 && mq.size() == 0) mphase = 2;
            if (pp) void'(mq.pop_front());
            if (psh) begin
                mq.push_back({mmem[mpc], 3'(mpc)});
                mpc++;
                if (m_fetch != 32'hFFFF) m_fetch++;
            end
        end
    endfunction

    task automatic compare();
        logic [19:0] h;
        h = (mq.size() != 0) ? mq[0] : 20'd0;
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("inst",  32'(out_inst),  32'(h[19:3]));
        chk("pc",    32'(out_pc),    32'(h[2:0]));
        chk("done",  32'(done),      32'(mphase == 2));
`ifdef IFU_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        chk("fetch_cnt", 32'(fetch_cnt), m_fetch);
`endif
    endtask

    // One cycle: drive after negedge, model the edge, compare at next negedge
    task automatic cyc(input logic f, input logic [2:0] fp, input logic r);
        flush = f; flush_pc = fp; out_ready = r;
        if (out_valid && r && !f) got.push_back({out_inst, out_pc});
        @(posedge clk);
        model_edge(f, fp, r);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst",  32'(out_inst),  32'd0);
        chk("rst_done",  32'(done),      32'd0);
        @(negedge clk);
        rstn = 1'b1;
        got.delete();
    endtask

    task automatic load(input logic rnd);
        for (int i = 0; i < INST_CAP; i++) begin
            mmem[i] = rnd ? INST_LEN'($urandom) : INST_LEN'(i + 1);
            dut.inst_mem[i] = mmem[i];
        end
    endtask

    typedef struct {
        logic                f;
        logic [2:0]          fp;
        logic                r;
        logic                ev;
        logic [INST_LEN-1:0] ei;
        logic [2:0]          ep;
        logic                ed;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n;
        bit reached;
        // full run, flush past end, restart from 0
        tbl[0]  = '{1'b0, 3'd0, 1'b1, 1'b1, 17'h1, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 1'b1, 1'b1, 17'h2, 3'd1, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 1'b1, 1'b1, 17'h3, 3'd2, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 1'b1, 1'b1, 17'h4, 3'd3, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 1'b1, 1'b1, 17'h5, 3'd4, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 1'b1, 1'b0, 17'h0, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 1'b1, 1'b0, 17'h0, 3'd0, 1'b1};
        tbl[7]  = '{1'b0, 3'd0, 1'b1, 1'b0, 17'h0, 3'd0, 1'b1};
        tbl[8]  = '{1'b1, 3'd7, 1'b1, 1'b0, 17'h0, 3'd0, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 1'b1, 1'b0, 17'h0, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 1'b1, 1'b0, 17'h0, 3'd0, 1'b1};
        tbl[11] = '{1'b0, 3'd0, 1'b1, 1'b0, 17'h0, 3'd0, 1'b1};
        tbl[12] = '{1'b1, 3'd0, 1'b1, 1'b0, 17'h0, 3'd0, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 1'b1, 1'b1, 17'h1, 3'd0, 1'b0};
        tbl[14] = '{1'b0, 3'd0, 1'b1, 1'b1, 17'h2, 3'd1, 1'b0};

        load(1'b0);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].f, tbl[i].fp, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_inst", i),  32'(out_inst),  32'(tbl[i].ei));
            chk($sformatf("tbl%0d_pc", i),    32'(out_pc),    32'(tbl[i].ep));
            chk($sformatf("tbl%0d_done", i),  32'(done),      32'(tbl[i].ed));
        end

        // backpressure: two prefetched, head held, pc stops at 2
        do_reset();
        repeat (6) cyc(1'b0, 3'd0, 1'b0);
        chk("bp_inst_held", 32'(out_inst), 32'h1);
        chk("bp_pc", 32'(dut.pc), 32'd2);
        repeat (3) cyc(1'b0, 3'd0, 1'b1);
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("bp_order%0d", i), 32'(got[i][19:3]), 32'(i + 1));

        // flush to pc 1 in the cycle that pops pc 3
        do_reset();
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            cyc(1'b0, 3'd0, 1'b1);
            reached = out_valid && (out_pc == 3'd3);
        end
        chk("fl_reach_pc3", 32'(reached), 32'd1);
        cyc(1'b1, 3'd1, 1'b1);
        chk("fl_bubble", 32'(out_valid), 32'd0);
        got.delete();
        cyc(1'b0, 3'd0, 1'b1);
        chk("fl_target_pc", 32'(out_pc), 32'd1);
        chk("fl_target_inst", 32'(out_inst), 32'h2);
        n = 0;
        while (!done && n < 20) begin
            cyc(1'b0, 3'd0, 1'b1);
            n++;
        end
        chk("fl_done", 32'(done), 32'd1);
        chk("fl_handshakes", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("fl_pc%0d", i), 32'(got[i][2:0]), 32'(i + 1));

        // asynchronous reset with two entries buffered
        do_reset();
        cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        chk("ar_valid_before", 32'(out_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_inst", 32'(out_inst), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b0, 3'd0, 1'b1);
        chk("ar_restart_pc", 32'(out_pc), 32'd0);
        chk("ar_restart_inst", 32'(out_inst), 32'h1);

`ifdef IFU_PERF_CNT_EN
        do_reset();
        repeat (4) cyc(1'b0, 3'd0, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            cyc(1'b0, 3'd0, 1'b1);
            n++;
        end
        chk("perf_stall", 32'(stall_cnt), 32'd3);
        chk("perf_fetch", 32'(fetch_cnt), 32'd5);
`endif

        // randomized traffic against the model
        load(1'b1);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
